// File: rtl/eq_stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// eq_stream_checker_pkg
// Shared definitions for the equality stream checker:
//   - state_t   : FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - sat_inc() : saturating increment for counters of any width up to 32
// ---------------------------------------------------------------------------
package eq_stream_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The counter is carried in a 32-bit container so one helper serves every
  // counter width; the ceiling is the all-ones value of the real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/eq_mask_cmp.sv
// ---------------------------------------------------------------------------
// eq_mask_cmp
// Combinational wildcard equality comparator (==? semantics).
// Bits set in mask are don't-care; match is 1 when every unmasked bit of a
// equals the corresponding bit of b. An all-ones mask always matches.
// Ports:
//   a, b   [WIDTH-1:0] in  : operands
//   mask   [WIDTH-1:0] in  : 1 = ignore this bit
//   match            out : wildcard-equal flag
// ---------------------------------------------------------------------------
module eq_mask_cmp
  import eq_stream_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             match
);

  logic [WIDTH-1:0] diff;

  assign diff  = (a ^ b) & ~mask;
  assign match = (diff == '0);

endmodule

// File: rtl/eq_stream_checker.sv
// ---------------------------------------------------------------------------
// eq_stream_checker
// Consumes a valid/ready stream of (a, b, mask) beats, classifies each beat as
// a wildcard match or mismatch, keeps saturating tallies, remembers the index
// of the first mismatch and produces a pass/fail summary at the end of a run.
// Ports:
//   clk, rst            in  : clock, synchronous active-high reset
//   start               in  : one-cycle pulse starting a run (IDLE/DONE only)
//   in_valid/in_ready       : beat handshake; in_ready is high only in RUN
//   in_a, in_b, in_mask in  : operands and don't-care mask
//   in_last             in  : final beat of the run
//   busy                out : RUN or DRAIN
//   done                out : run complete, held until start or rst
//   pass                out : no mismatches and at least one match
//   match_cnt           out : saturating count of matching beats
//   mismatch_cnt        out : saturating count of mismatching beats
//   first_mm_valid      out : a mismatch has been seen this run
//   first_mm_idx        out : 0-based index of the first mismatching beat
// ---------------------------------------------------------------------------
module eq_stream_checker
  import eq_stream_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mm_valid,
  output logic [CNT_W-1:0] first_mm_idx
);

  state_t           state;
  logic             accept;
  logic             start_run;
  logic             beat_match;
  logic [CNT_W-1:0] beat_idx;
  logic             res_valid;
  logic             res_match;
  logic [CNT_W-1:0] res_idx;
  logic [CNT_W-1:0] match_nxt;
  logic [CNT_W-1:0] mismatch_nxt;

  // Handshake and status flags are pure decodes of the state register.
  assign in_ready  = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign start_run = start && ((state == S_IDLE) || (state == S_DONE));

  eq_mask_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a     (in_a),
    .b     (in_b),
    .mask  (in_mask),
    .match (beat_match)
  );

  // Tallies after the result currently held in the compare stage commits.
  // The DRAIN transition uses these so pass sees the final beat.
  always_comb begin
    match_nxt    = match_cnt;
    mismatch_nxt = mismatch_cnt;
    if (res_valid) begin
      if (res_match) begin
        match_nxt = CNT_W'(sat_inc(32'(match_cnt), CNT_W));
      end else begin
        mismatch_nxt = CNT_W'(sat_inc(32'(mismatch_cnt), CNT_W));
      end
    end
  end

  // Run-control FSM. DRAIN lasts one cycle so the last beat's compare
  // result commits before done/pass are presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pass  <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept && in_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          pass  <= (mismatch_nxt == '0) && (match_nxt != '0);
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            pass  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Compare stage register and commit logic. A result is captured on
  // acceptance and folded into the tallies on the following edge; a new
  // run clears everything that describes the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx       <= '0;
      res_valid      <= 1'b0;
      res_match      <= 1'b0;
      res_idx        <= '0;
      match_cnt      <= '0;
      mismatch_cnt   <= '0;
      first_mm_valid <= 1'b0;
      first_mm_idx   <= '0;
    end else if (start_run) begin
      beat_idx       <= '0;
      res_valid      <= 1'b0;
      res_match      <= 1'b0;
      res_idx        <= '0;
      match_cnt      <= '0;
      mismatch_cnt   <= '0;
      first_mm_valid <= 1'b0;
      first_mm_idx   <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_match <= beat_match;
        res_idx   <= beat_idx;
        beat_idx  <= CNT_W'(sat_inc(32'(beat_idx), CNT_W));
      end
      match_cnt    <= match_nxt;
      mismatch_cnt <= mismatch_nxt;
      // Only the first mismatch of a run is recorded.
      if (res_valid && !res_match && !first_mm_valid) begin
        first_mm_valid <= 1'b1;
        first_mm_idx   <= res_idx;
      end
    end
  end

endmodule

// File: tb/tb_eq_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_eq_stream_checker
// Table-driven bench for eq_stream_checker. Each run in the vector table has
// its expected summary computed from the hand-written per-beat expectations
// and pushed to a scoreboard queue when the run is driven; the summary is
// popped and compared once the DUT reports done. A second instance built with
// CNT_W=3 shares the stimulus and is used for the saturation corner.
// ---------------------------------------------------------------------------
module tb_eq_stream_checker;

  typedef struct {
    logic       valid;
    logic       st;
    logic       last;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mask;
    logic       exp_match;
  } vec_t;

  typedef struct {
    int unsigned match_cnt;
    int unsigned mismatch_cnt;
    logic        first_valid;
    int unsigned first_idx;
    logic        pass;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  in_mask;
  logic        in_last;

  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] match_cnt;
  logic [15:0] mismatch_cnt;
  logic        first_mm_valid;
  logic [15:0] first_mm_idx;

  logic        s3_in_ready;
  logic        s3_busy;
  logic        s3_done;
  logic        s3_pass;
  logic [2:0]  s3_match_cnt;
  logic [2:0]  s3_mismatch_cnt;
  logic        s3_first_mm_valid;
  logic [2:0]  s3_first_mm_idx;

  vec_t        vecs[32];
  expect_t     sb_queue[$];
  int          checks;
  int          errors;

  eq_stream_checker #(
    .WIDTH (8),
    .CNT_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_mask        (in_mask),
    .in_last        (in_last),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .match_cnt      (match_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .first_mm_valid (first_mm_valid),
    .first_mm_idx   (first_mm_idx)
  );

  eq_stream_checker #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut3 (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (s3_in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_mask        (in_mask),
    .in_last        (in_last),
    .busy           (s3_busy),
    .done           (s3_done),
    .pass           (s3_pass),
    .match_cnt      (s3_match_cnt),
    .mismatch_cnt   (s3_mismatch_cnt),
    .first_mm_valid (s3_first_mm_valid),
    .first_mm_idx   (s3_first_mm_idx)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance across one rising edge and land on the falling edge, where
  // outputs are sampled and new inputs are driven.
  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Pop the oldest expected run summary and compare it against the DUT.
  task automatic checkOutput(input string tag);
    expect_t e;
    if (sb_queue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard actual=empty expected=entry", tag);
    end else begin
      e = sb_queue.pop_front();
      checkValue({tag, "_done"},     32'(done), 32'd1);
      checkValue({tag, "_match"},    32'(match_cnt), e.match_cnt);
      checkValue({tag, "_mismatch"}, 32'(mismatch_cnt), e.mismatch_cnt);
      checkValue({tag, "_fmv"},      32'(first_mm_valid), 32'(e.first_valid));
      if (e.first_valid) begin
        checkValue({tag, "_fmi"}, 32'(first_mm_idx), e.first_idx);
      end
      checkValue({tag, "_pass"},     32'(pass), 32'(e.pass));
    end
  endtask

  // Drive one run from the vector table: push its expected summary, pulse
  // start, present the beats, then wait (bounded) for done. With hold set,
  // a bogus beat is left on the bus through DRAIN/DONE and must be ignored.
  task automatic applyStimulus(input string tag, input int first, input int count,
                               input bit hold);
    expect_t e;
    int      idx;
    int      lat;
    e   = '{0, 0, 1'b0, 0, 1'b0};
    idx = 0;
    for (int i = first; i < first + count; i++) begin
      if (vecs[i].valid) begin
        if (vecs[i].exp_match) begin
          e.match_cnt++;
        end else begin
          e.mismatch_cnt++;
          if (!e.first_valid) begin
            e.first_valid = 1'b1;
            e.first_idx   = idx;
          end
        end
        idx++;
      end
    end
    e.pass = (e.mismatch_cnt == 0) && (e.match_cnt != 0);
    sb_queue.push_back(e);

    start = 1'b1;
    stepClock();
    start = 1'b0;
    checkValue({tag, "_start_busy"}, 32'(busy), 32'd1);
    checkValue({tag, "_start_done"}, 32'(done), 32'd0);

    for (int i = first; i < first + count; i++) begin
      in_valid = vecs[i].valid;
      start    = vecs[i].st;
      in_last  = vecs[i].last;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_mask  = vecs[i].mask;
      if (vecs[i].valid) begin
        checkValue({tag, "_run_ready"}, 32'(in_ready), 32'd1);
      end
      stepClock();
    end

    start    = 1'b0;
    in_valid = hold;
    in_last  = hold;
    in_a     = 8'h00;
    in_b     = 8'hFF;
    in_mask  = 8'h00;
    // The cycle after the last acceptance is DRAIN; done follows one later.
    lat = 1;
    checkValue({tag, "_drain_busy"},  32'(busy), 32'd1);
    checkValue({tag, "_drain_ready"}, 32'(in_ready), 32'd0);
    while (done !== 1'b1 && lat < 10) begin
      stepClock();
      lat++;
    end
    checkValue({tag, "_done_latency"}, 32'(lat), 32'd2);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        stepClock();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    in_mask  = 8'h00;
    in_last  = 1'b0;

    // Vector table: {valid, start, last, a, b, mask, expected match}.
    // Run A: four exact matches.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h0F, 8'h0F, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1};
    // Run B: masked match, unmasked mismatch, all-ones mask.
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'hA4, 8'h01, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'hA4, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b1};
    // Run C: eight beats, mismatches at indices 2 and 5.
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h11, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'hA2, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h33, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h44, 8'h44, 8'h0F, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h54, 8'h0E, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h66, 8'h66, 8'h00, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h77, 8'h77, 8'h00, 1'b1};
    // Run D: valid pattern 1,0,1,1,0,1 with a stray start in a gap.
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h11, 8'h00, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h33, 8'h00, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h44, 8'h44, 8'h00, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h54, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 8'h66, 8'h66, 8'h00, 1'b1};
    // Run E: single-beat run.
    vecs[21] = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1};
    // Run F: ten matching beats for the saturation corner.
    for (int i = 0; i < 10; i++) begin
      vecs[22 + i] = '{1'b1, 1'b0, (i == 9), 8'(i * 3), 8'(i * 3), 8'h00, 1'b1};
    end

    stepClock();
    stepClock();
    rst = 1'b0;

    checkValue("reset_done",     32'(done), 32'd0);
    checkValue("reset_busy",     32'(busy), 32'd0);
    checkValue("reset_ready",    32'(in_ready), 32'd0);
    checkValue("reset_pass",     32'(pass), 32'd0);
    checkValue("reset_match",    32'(match_cnt), 32'd0);
    checkValue("reset_mismatch", 32'(mismatch_cnt), 32'd0);
    checkValue("reset_fmv",      32'(first_mm_valid), 32'd0);
    checkValue("reset_fmi",      32'(first_mm_idx), 32'd0);

    applyStimulus("runA", 0, 4, 1'b0);
    applyStimulus("runB", 4, 3, 1'b0);
    applyStimulus("runC", 7, 8, 1'b0);
    applyStimulus("runD", 15, 6, 1'b1);

    // Mid-run reset after three beats abandons the run entirely.
    start = 1'b1;
    stepClock();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_a     = 8'(i + 1);
      in_b     = 8'(i + 1);
      in_mask  = 8'h00;
      stepClock();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    stepClock();
    rst = 1'b0;
    checkValue("midrst_match",    32'(match_cnt), 32'd0);
    checkValue("midrst_mismatch", 32'(mismatch_cnt), 32'd0);
    checkValue("midrst_busy",     32'(busy), 32'd0);
    checkValue("midrst_ready",    32'(in_ready), 32'd0);
    checkValue("midrst_done",     32'(done), 32'd0);
    checkValue("midrst_pass",     32'(pass), 32'd0);
    stepClock();
    checkValue("midrst_match_hold", 32'(match_cnt), 32'd0);
    checkValue("midrst_idle",       32'(busy), 32'd0);

    applyStimulus("runE", 21, 1, 1'b0);
    applyStimulus("runF", 22, 10, 1'b0);

    // The narrow instance saw the same ten matches and must sit at 7.
    checkValue("sat3_done",     32'(s3_done), 32'd1);
    checkValue("sat3_match",    32'(s3_match_cnt), 32'd7);
    checkValue("sat3_mismatch", 32'(s3_mismatch_cnt), 32'd0);
    checkValue("sat3_fmv",      32'(s3_first_mm_valid), 32'd0);
    checkValue("sat3_fmi",      32'(s3_first_mm_idx), 32'd0);
    checkValue("sat3_pass",     32'(s3_pass), 32'd1);

    // Restart from DONE: done drops and counters clear on the start edge.
    start = 1'b1;
    stepClock();
    start = 1'b0;
    checkValue("restart_done",       32'(done), 32'd0);
    checkValue("restart_match",      32'(match_cnt), 32'd0);
    checkValue("restart3_done",      32'(s3_done), 32'd0);
    checkValue("restart3_match",     32'(s3_match_cnt), 32'd0);
    checkValue("restart3_ready",     32'(s3_in_ready), 32'd1);
    checkValue("restart3_busy",      32'(s3_busy), 32'd1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_a     = 8'hC3;
    in_b     = 8'hC3;
    stepClock();
    in_valid = 1'b0;
    in_last  = 1'b0;
    stepClock();
    checkValue("restart3_final_match", 32'(s3_match_cnt), 32'd1);
    checkValue("restart3_final_done",  32'(s3_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_stream_checker.md
Name: eq_stream_checker

Overview:
- Sequential consumer for equality comparisons. It accepts a stream of operand pairs (a, b) plus a don't-care mask over a valid/ready handshake.
- Each beat is classified as a wildcard match or a mismatch, i.e. synthesizable ==? semantics: masked bits are ignored.
- It keeps saturating match/mismatch tallies and records the index of the first mismatch.
- It sits downstream of the equality demo/comparator stage and turns its per-sample results into a pass/fail summary for the bench and board LEDs.

Parameters:
- WIDTH, 8, operand width in bits.
- CNT_W, 16, width of the beat index and tally counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new check run.
- in_valid  input  1  operand beat present.
- in_ready  output  1  checker can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_mask  input  WIDTH  don't-care mask; 1 = ignore this bit.
- in_last  input  1  marks the final beat of the run.
- busy  output  1  run in progress (RUN or DRAIN).
- done  output  1  high from run completion until the next start or rst.
- pass  output  1  valid when done; 1 iff mismatch_cnt == 0 and at least one beat was checked.
- match_cnt  output  CNT_W  number of matching beats.
- mismatch_cnt  output  CNT_W  number of mismatching beats.
- first_mm_valid  output  1  a mismatch has been recorded this run.
- first_mm_idx  output  CNT_W  0-based index of the first mismatching beat.

Behaviour:
- Reset is synchronous and active-high: rst sampled high on a rising clk edge clears the block.
  - All outputs and registers go to 0 and the FSM goes to IDLE.
  - This applies mid-run too: the run is abandoned, no done is asserted, and in-flight results are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start -> RUN, clearing counters, index, first_mm_* and pass.
  - RUN: in_ready=1. A beat is accepted when in_valid && in_ready.
    - An accepted beat with in_last=1 -> DRAIN.
    - start while in RUN is ignored.
  - DRAIN: in_ready=0 for exactly one cycle while the last result commits -> DONE.
  - DONE: done=1, pass valid, in_ready=0. start -> RUN, with the same clearing as from IDLE and done dropping in the same cycle.
- Compare stage, registered one cycle after acceptance:
  - diff = (in_a ^ in_b) & ~in_mask.
  - match = (diff == 0). mask all-ones -> always a match.
  - The stage register holds a result-valid bit, the match bit and the beat index.
- Commit, one cycle after acceptance:
  - match_cnt or mismatch_cnt increments.
  - On the first mismatch, first_mm_idx is set to the beat index and first_mm_valid goes to 1. Later mismatches do not overwrite it.
- Beat index starts at 0 per run and increments per accepted beat. It saturates at 2^CNT_W-1; indices beyond that report the saturated value.
- Tallies saturate at 2^CNT_W-1 and never wrap.
- Throughput: one beat per cycle in RUN. Latency is 1 cycle from acceptance to counter update. done rises 2 cycles after the last beat is accepted.
- A beat presented while in_ready=0 is not consumed; the source must hold it.
- in_last on a run's first beat gives a valid 1-beat run.
- pass=0 if a run somehow completes with zero beats checked; this is unreachable via the handshake but defined.

Decomposition:
- Shared package / include:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2, S_DONE=2'd3.
  - saturating-increment helper function.
- One natural sub-module: eq_mask_cmp, a combinational wildcard comparator (WIDTH param; a, b, mask -> match). It is reused by the equality demo for ==? comparisons.
- FSM, compare register and counters stay in eq_stream_checker.

Test Plan:
- Reset then start; 4 beats (a,b,mask) = (0x3C,0x3C,0), (0xAA,0xAA,0), (0x0F,0x0F,0), (0xFF,0xFF,0) with last on beat 3 -> match_cnt=4, mismatch_cnt=0, pass=1, done 2 cycles after beat 3, first_mm_valid=0.
- Masked compare: a=0xA5, b=0xA4, mask=0x01 -> match. Then a=0xA5, b=0xA4, mask=0x00 -> mismatch. Then a=0x00, b=0xFF, mask=0xFF, last -> match. Expect match=2, mismatch=1, first_mm_idx=1, pass=0.
- Mismatches at indices 2 and 5 in an 8-beat run -> first_mm_idx=2 (not 5), mismatch_cnt=2, match_cnt=6.
- Backpressure and gaps: in_valid toggled 1,0,1,1,0,1 (last) -> exactly 4 beats counted. A beat held while in_ready=0 in DRAIN/DONE is not counted.
- Assert rst for one cycle after 3 beats mid-run -> all outputs 0, state IDLE. A new start with a 1-beat last run gives match_cnt=1, done=1, with no stale counts.
- CNT_W=3 build, 10 matching beats -> match_cnt saturates at 7. Then a new start gives counters 0 and done falls on the start cycle.
